oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, number of bytes copied per transfer.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, first destination address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port dma_wr  input  1  one-cycle pulse; the CPU wrote the DMA register (FF46).
REQ-006 SHALL have port dma_data  input  8  value written to FF46, the source page.
REQ-007 SHALL have port dma_rdata  input  8  read data from the memory unit, valid in the same cycle as dma_re.
REQ-008 SHALL have port dma_addr  output  16  bus address driven while the transfer owns the bus.
REQ-009 SHALL have port dma_wdata  output  8  write data.
REQ-010 SHALL have port dma_re  output  1  read strobe.
REQ-011 SHALL have port dma_we  output  1  write strobe.
REQ-012 SHALL have port dma_busy  output  1  transfer active; the top-level bus mux gives the bus to this block and stalls the datapath.
REQ-013 SHALL have port dma_done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-014 SHALL implement the FSM states IDLE, START, READ and WRITE.
REQ-015 IDLE: a sampled dma_wr SHALL latch src_page, clear idx (8 bits) and move to START.
REQ-016 START: one cycle with dma_busy=1 and no strobes, then move to READ.
REQ-017 READ: SHALL drive dma_addr={src_page,idx}, dma_re=1, dma_we=0, and latch dma_rdata into data_q at the cycle end, then move to WRITE.
REQ-018 WRITE: SHALL drive dma_addr=OAM_BASE+idx, dma_wdata=data_q, dma_we=1, dma_re=0.
REQ-019 WRITE exit: if idx==DMA_LEN-1, go to IDLE and assert dma_done in the next cycle; otherwise increment idx and go to READ.
REQ-020 Source page mapping: dma_data 8'h00-8'hDF SHALL be used as-is; 8'hE0-8'hFF SHALL be mapped to dma_data-8'h20 (echo RAM), so that OAM and I/O are never read as the source.
REQ-021 dma_busy SHALL be 1 in the START, READ and WRITE states, and 0 in IDLE.
REQ-022 Latency: with dma_wr high at edge N, dma_busy SHALL be high from cycle N+1 through N+1+2*DMA_LEN (321 cycles), and dma_done SHALL be high only in cycle N+2+2*DMA_LEN.
REQ-023 dma_re and dma_we SHALL never both be 1; both SHALL be 0 outside READ and WRITE.
REQ-024 In IDLE, dma_addr and dma_wdata SHALL be 0.
REQ-025 A dma_wr during START, READ or WRITE SHALL restart the transfer: latch the new page, clear idx, enter START next cycle, and emit no dma_done for the aborted transfer.
REQ-026 If dma_wr arrives in the cycle where the final WRITE completes, the restart SHALL take precedence and dma_done SHALL be suppressed.
REQ-027 The idx comparison SHALL use the full 8-bit width; destination addition is 16-bit with no wrap beyond OAM_BASE+DMA_LEN-1.

Reset
REQ-028 When rst is asserted, at any time, the block SHALL go to IDLE with idx=0, src_page=0, data_q=0, and all outputs 0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no dma_done; after release the block SHALL wait for a new dma_wr.

Verification
REQ-030 Basic copy: preload C000-C09F with i^8'h5A, pulse dma_wr with dma_data=8'hC0 -> 160 writes FE00..FE9F with matching data, busy for 321 cycles, one dma_done.
REQ-031 Echo mapping: dma_data=8'hE1 -> reads at D100-D19F; no dma_addr in E000-FFFF during READ.
REQ-032 Restart: second dma_wr (8'h80) during READ at idx=50 -> START next cycle, idx restarts at 0 from 8000, exactly one dma_done, 321 busy cycles after the restart.
REQ-033 Async reset at idx=100 in WRITE -> outputs 0 immediately, with no dma_done; a subsequent dma_wr (8'hC0) completes normally.
REQ-034 Strobe check over a full transfer -> dma_re&dma_we never 1; 160 re pulses and 160 we pulses, alternating and starting with re.
REQ-035 Boundary: dma_wr coinciding with the final WRITE (idx=159) -> no dma_done; a new transfer runs to completion.

Source files
------------

// File: rtl/oam_dma.sv
// Copies a DMA_LEN-byte block from a source page into OAM, one read/write pair
// per byte, taking over the system bus while the copy runs.
//
// state | meaning
// IDLE  | bus released, waiting for a write to the DMA register
// START | bus claimed for one cycle, no strobes yet
// READ  | read source byte {src_page, idx}
// WRITE | write that byte to OAM_BASE + idx
module oam_dma #(
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_wr,
  input  logic [7:0]  dma_data,
  input  logic [7:0]  dma_rdata,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_re,
  output logic        dma_we,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     state;
  logic [7:0] src_page;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic [7:0] page_mapped;

  // Pages E0-FF alias down to C0-DF so OAM and I/O are never used as source.
  assign page_mapped = (dma_data >= 8'hE0) ? (dma_data - 8'h20) : dma_data;

  assign dma_wdata = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      src_page <= 8'h00;
      idx      <= 8'h00;
      data_q   <= 8'h00;
      dma_addr <= 16'h0000;
      dma_re   <= 1'b0;
      dma_we   <= 1'b0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      // A register write restarts from any state, including the last WRITE,
      // which also swallows that transfer's done pulse.
      if (dma_wr) begin
        state    <= START;
        src_page <= page_mapped;
        idx      <= 8'h00;
        data_q   <= 8'h00;
        dma_addr <= 16'h0000;
        dma_re   <= 1'b0;
        dma_we   <= 1'b0;
        dma_busy <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            dma_busy <= 1'b0;
          end
          START: begin
            state    <= READ;
            dma_addr <= {src_page, idx};
            dma_re   <= 1'b1;
            dma_we   <= 1'b0;
          end
          READ: begin
            state    <= WRITE;
            data_q   <= dma_rdata;
            dma_addr <= OAM_BASE + {8'h00, idx};
            dma_re   <= 1'b0;
            dma_we   <= 1'b1;
          end
          WRITE: begin
            data_q <= 8'h00;
            dma_we <= 1'b0;
            if (idx == LAST_IDX) begin
              state    <= IDLE;
              dma_addr <= 16'h0000;
              dma_busy <= 1'b0;
              dma_done <= 1'b1;
            end else begin
              state    <= READ;
              idx      <= idx + 8'd1;
              dma_addr <= {src_page, idx + 8'd1};
              dma_re   <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            dma_addr <= 16'h0000;
            dma_re   <= 1'b0;
            dma_we   <= 1'b0;
            dma_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a flat memory model feeds reads, and each
// transfer is tracked as (source page, bytes read, bytes written, cycle count).
module tb_oam_dma;

  localparam int LEN  = 160;
  localparam int BASE = 'hFE00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dma_wr = 1'b0;
  logic [7:0]  dma_data = 8'h00;
  logic [7:0]  dma_rdata;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_re;
  logic        dma_we;
  logic        dma_busy;
  logic        dma_done;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];

  always #5 clk = ~clk;

  assign dma_rdata = dma_re ? mem[dma_addr] : 8'h00;

  oam_dma #(.DMA_LEN(LEN), .OAM_BASE(16'hFE00)) dut (
    .clk       (clk),
    .rst       (rst),
    .dma_wr    (dma_wr),
    .dma_data  (dma_data),
    .dma_rdata (dma_rdata),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_re    (dma_re),
    .dma_we    (dma_we),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cur_map, rd_cnt, wr_cnt, k;
  int busy_cnt, busy_first, busy_last, done_cnt, done_k;
  bit last_re, active;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int page_map(input int p);
    if (p >= 'hE0) return p - 'h20;
    return p;
  endfunction

  task automatic new_transfer(input int page, input bit act);
    cur_map    = page_map(page);
    active     = act;
    rd_cnt     = 0;
    wr_cnt     = 0;
    k          = 0;
    busy_cnt   = 0;
    busy_first = 0;
    busy_last  = 0;
    done_cnt   = 0;
    done_k     = 0;
    last_re    = 1'b0;
  endtask

  // Sample the current cycle (called at a falling edge), then advance one cycle.
  task automatic step();
    k++;
    chk("re_we_excl", int'(dma_re & dma_we), 0);
    if (!dma_busy) begin
      chk("idle_bus", int'({dma_addr, dma_wdata}), 0);
      chk("idle_strobe", int'({dma_re, dma_we}), 0);
    end
    if (active && k == 1) begin
      chk("start_busy", int'(dma_busy), 1);
      chk("start_strobe", int'({dma_re, dma_we}), 0);
    end
    if (dma_busy) begin
      busy_cnt++;
      if (busy_first == 0) busy_first = k;
      busy_last = k;
    end
    if (dma_done) begin
      done_cnt++;
      if (done_k == 0) done_k = k;
    end
    if (dma_re) begin
      chk("alt_re", int'(last_re), 0);
      last_re = 1'b1;
      chk("rd_addr", int'(dma_addr), cur_map * 256 + rd_cnt);
      chk("rd_not_high", int'(dma_addr >= 16'hE000), 0);
      rd_cnt++;
    end
    if (dma_we) begin
      chk("alt_we", int'(last_re), 1);
      last_re = 1'b0;
      chk("wr_addr", int'(dma_addr), BASE + wr_cnt);
      chk("wr_data", int'(dma_wdata), int'(mem[16'(cur_map * 256 + wr_cnt)]));
      oam[dma_addr[7:0]] = dma_wdata;
      wr_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d);
    dma_wr   = 1'b1;
    dma_data = d;
    step();
    dma_wr   = 1'b0;
    dma_data = 8'h00;
    new_transfer(int'(d), 1'b1);
  endtask

  task automatic advance_to(input int rd, input int wr);
    int guard = 0;
    while (!(rd_cnt == rd && wr_cnt == wr) && guard < 400) begin
      step();
      guard++;
    end
    chk("reach_point", int'(rd_cnt == rd && wr_cnt == wr), 1);
  endtask

  task automatic finish_check(input string tag);
    while (k < 2 * LEN + 6) step();
    chk({tag, "_busy_cnt"}, busy_cnt, 2 * LEN + 1);
    chk({tag, "_busy_first"}, busy_first, 1);
    chk({tag, "_busy_last"}, busy_last, 2 * LEN + 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_k, 2 * LEN + 2);
    chk({tag, "_reads"}, rd_cnt, LEN);
    chk({tag, "_writes"}, wr_cnt, LEN);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 65536; i++) mem[16'(i)] = 8'($urandom);
    for (int i = 0; i < LEN; i++) mem[16'('hC000 + i)] = 8'(i ^ 'h5A);
    for (int i = 0; i < 256; i++) oam[8'(i)] = 8'h00;

    #12;
    chk("rst_ctl", int'({dma_busy, dma_re, dma_we, dma_done}), 0);
    chk("rst_addr", int'(dma_addr), 0);
    chk("rst_wdata", int'(dma_wdata), 0);
    @(negedge clk);
    rst = 1'b0;
    new_transfer(0, 1'b0);
    repeat (3) step();

    // Basic copy from C000
    pulse(8'hC0);
    finish_check("basic");
    for (int i = 0; i < LEN; i++) chk("oam_basic", int'(oam[8'(i)]), i ^ 'h5A);

    // Echo page E1 reads from D100
    pulse(8'hE1);
    finish_check("echo");

    // Restart during READ of idx 50
    pulse(8'hC0);
    advance_to(50, 50);
    chk("restart_in_read", int'(dma_re), 1);
    pulse(8'h80);
    finish_check("restart");

    // Async reset during WRITE of idx 100
    pulse(8'hC0);
    advance_to(101, 100);
    chk("rst_in_write", int'(dma_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctl", int'({dma_busy, dma_re, dma_we, dma_done}), 0);
    chk("midrst_addr", int'(dma_addr), 0);
    chk("midrst_wdata", int'(dma_wdata), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    new_transfer(0, 1'b0);
    repeat (20) step();
    chk("post_rst_busy", busy_cnt, 0);
    chk("post_rst_done", done_cnt, 0);
    chk("post_rst_reads", rd_cnt, 0);
    pulse(8'hC0);
    finish_check("post_rst");

    // Restart coinciding with the final WRITE
    pulse(8'hC0);
    advance_to(LEN, LEN - 1);
    chk("final_write", int'(dma_we), 1);
    pulse(8'($urandom_range(0, 255)));
    finish_check("final_restart");

    // Random pages
    repeat (4) begin
      pulse(8'($urandom_range(0, 255)));
      finish_check("rand");
    end

    // Random restart points
    repeat (2) begin
      pulse(8'($urandom_range(0, 255)));
      r = int'($urandom_range(0, LEN - 1));
      advance_to(r, r);
      pulse(8'($urandom_range(0, 255)));
      finish_check("rand_restart");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
